// File: rtl/btn_sched_pkg.sv
// Shared defaults and helpers for the button event scheduler.
package btn_sched_pkg;

  localparam int unsigned DefNBtn        = 4;
  localparam int unsigned DefPrescale    = 250000;
  localparam int unsigned DefStableTicks = 4;
  localparam int unsigned DefFifoDepth   = 4;

  // Width needed to hold a button index 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchronizer, tick-driven stability counter and debounced level.
module btn_debounce_cell
  import btn_sched_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic debounced_o
);

  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;
  logic            synced;

  assign synced      = sync_q[1];
  assign debounced_o = deb_q;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (synced == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(STABLE_TICKS)) begin
      deb_d = synced;
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounces N_BTN buttons, turns presses into pending requests and queues them round-robin.
module button_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int unsigned N_BTN        = DefNBtn,
  parameter int unsigned PRESCALE     = DefPrescale,
  parameter int unsigned STABLE_TICKS = DefStableTicks,
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_BTN-1:0]               btn_noisy,
  output logic [N_BTN-1:0]               debounced,
  output logic                           evt_valid,
  output logic [idx_width(N_BTN)-1:0]    evt_id,
  input  logic                           evt_ready,
  output logic                           evt_overflow
);

  localparam int unsigned IdxW = idx_width(N_BTN);
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [PreW-1:0]  pre_q;
  logic             tick;
  logic [N_BTN-1:0] deb_prev_q, rise;
  logic [N_BTN-1:0] pending_q, pending_d, gnt_mask, pend_sh;
  logic [IdxW-1:0]  last_grant_q, gnt_idx;
  logic             gnt_valid;
  int unsigned      cand;

  logic [IdxW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full, pop, do_push, drop;

  assign tick = (pre_q == PreW'(PRESCALE - 1));

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    btn_debounce_cell #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick),
      .btn_i      (btn_noisy[i]),
      .debounced_o(debounced[i])
    );
  end

  assign rise = debounced & ~deb_prev_q;

  // Round-robin: first pending bit at or after last_grant+1, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    pend_sh   = '0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      cand    = (int'(last_grant_q) + k) % N_BTN;
      pend_sh = pending_q >> cand;
      if (!gnt_valid && pend_sh[0]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    gnt_mask = '0;
    if (gnt_valid) gnt_mask[gnt_idx] = 1'b1;
    // A rise on an already pending bit merges; a rise on the granted bit is a new press.
    pending_d = (pending_q & ~gnt_mask) | rise;
  end

  assign evt_valid = (cnt_q != '0);
  assign evt_id    = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign full      = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign do_push   = gnt_valid & (~full | pop);
  assign drop      = gnt_valid & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      deb_prev_q   <= '0;
      pending_q    <= '0;
      last_grant_q <= IdxW'(N_BTN - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pre_q        <= tick ? '0 : pre_q + PreW'(1);
      deb_prev_q   <= debounced;
      pending_q    <= pending_d;
      if (gnt_valid) last_grant_q <= gnt_idx;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q        <= cnt_d;
      if (drop) evt_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; evt_id is gated by evt_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= gnt_idx;
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler with a small prescaler.
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_noisy;
  logic [3:0] debounced;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic       evt_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  button_event_scheduler #(
    .N_BTN       (4),
    .PRESCALE    (4),
    .STABLE_TICKS(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_noisy   (btn_noisy),
    .debounced   (debounced),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected expected event-free", name);
  endtask

  // Monitor: every accepted event is compared against the scoreboard head.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_evt: got id %0d expected no event", evt_id);
        end else begin
          e = exp_q.pop_front();
          check("evt_id_order", int'(evt_id), e);
        end
      end
    end
  end

  task automatic wait_deb(input int i, input bit lvl, output int cycles);
    logic [3:0] d;
    for (cycles = 1; cycles <= 60; cycles++) begin
      @(negedge clk);
      d = debounced >> i;
      if (d[0] == lvl) return;
    end
    fail_now("debounce_timeout");
  endtask

  task automatic wait_all_low();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (debounced == 4'b0000) return;
    end
    fail_now("release_timeout");
  endtask

  task automatic press(input int i, input bit expect_evt);
    int c;
    @(posedge clk);
    #1;
    btn_noisy = btn_noisy | (4'b0001 << i);
    if (expect_evt) exp_q.push_back(i);
    wait_deb(i, 1'b1, c);
  endtask

  task automatic release_btn(input int i);
    int c;
    @(posedge clk);
    #1;
    btn_noisy = btn_noisy & ~(4'b0001 << i);
    wait_deb(i, 1'b0, c);
  endtask

  task automatic release_all();
    @(posedge clk);
    #1;
    btn_noisy = 4'b0000;
    wait_all_low();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    int  stale;
    bit  seen;
    bit  found;
    rst       = 1'b1;
    btn_noisy = 4'b0000;
    evt_ready = 1'b0;
    settle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_debounced", int'(debounced), 0);
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_evt_id", int'(evt_id), 0);
    check("rst_overflow", int'(evt_overflow), 0);

    // Simultaneous presses on 0, 1, 3 drain one per cycle in index order.
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    btn_noisy = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      found = evt_valid;
    end
    if (!found) fail_now("burst_timeout");
    check("burst_debounced", int'(debounced), 4'b1011);
    @(negedge clk);
    check("burst_valid_2nd", int'(evt_valid), 1);
    @(negedge clk);
    check("burst_valid_3rd", int'(evt_valid), 1);
    @(negedge clk);
    check("burst_valid_end", int'(evt_valid), 0);
    release_all();
    settle(4);
    check("release_no_evt", int'(evt_valid), 0);

    // Bouncing button 2 produces a single event after it settles.
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      btn_noisy[2] = ((c / 3) % 2 == 0);
      if (debounced[2]) seen = 1'b1;
    end
    check("bounce_no_deb", int'(seen), 0);
    @(posedge clk);
    #1;
    btn_noisy = 4'b0100;
    exp_q.push_back(2);
    wait_deb(2, 1'b1, n);
    check("bounce_latency_16_20", int'(n >= 16 && n <= 20), 1);
    settle(10);
    check("bounce_one_evt", exp_q.size(), 0);

    // Release generates no event.
    @(posedge clk);
    #1;
    btn_noisy = 4'b0000;
    wait_deb(2, 1'b0, n);
    check("release_latency_16_20", int'(n >= 16 && n <= 20), 1);
    settle(10);
    check("release_evt_valid", int'(evt_valid), 0);

    // Full FIFO with a pop in the same cycle as the new push: nothing dropped.
    evt_ready = 1'b0;
    press(0, 1'b1);
    press(1, 1'b1);
    press(2, 1'b1);
    press(3, 1'b1);
    settle(5);
    check("full_valid", int'(evt_valid), 1);
    check("full_head", int'(evt_id), 0);
    release_btn(0);
    press(0, 1'b1);
    // debounced[0] rose at the last edge; the push lands two edges later.
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
    settle(3);
    check("full_pop_overflow", int'(evt_overflow), 0);
    check("full_pop_remaining", exp_q.size(), 4);
    check("full_pop_head", int'(evt_id), 1);
    evt_ready = 1'b1;
    settle(8);
    check("full_pop_drained", int'(evt_valid), 0);
    check("full_pop_sb_empty", exp_q.size(), 0);
    release_all();

    // Fifth press while full is dropped and flagged.
    evt_ready = 1'b0;
    press(0, 1'b1);
    press(1, 1'b1);
    press(2, 1'b1);
    press(3, 1'b1);
    release_btn(0);
    press(0, 1'b0);
    settle(5);
    check("ovf_flag", int'(evt_overflow), 1);
    check("ovf_valid", int'(evt_valid), 1);
    check("ovf_head", int'(evt_id), 0);
    settle(3);
    check("ovf_head_stable", int'(evt_id), 0);
    evt_ready = 1'b1;
    settle(8);
    check("ovf_drained", int'(evt_valid), 0);
    check("ovf_sb_empty", exp_q.size(), 0);
    check("ovf_sticky", int'(evt_overflow), 1);
    evt_ready = 1'b0;
    release_all();

    // Reset with three queued events discards them all.
    press(0, 1'b1);
    press(1, 1'b1);
    press(2, 1'b1);
    settle(5);
    check("pre_rst_valid", int'(evt_valid), 1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    btn_noisy = 4'b0000;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_id", int'(evt_id), 0);
    check("mid_rst_overflow", int'(evt_overflow), 0);
    check("mid_rst_debounced", int'(debounced), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    evt_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (evt_valid) stale++;
    end
    check("post_rst_no_stale", stale, 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
